// File: rtl/pulse_generator.sv
// pulse_generator: free-running periodic strobe, one-cycle high pulse every Period clocks.
module pulse_generator #(
  parameter int Period = 16
) (
  input  logic clk,
  input  logic rst,
  output logic pulse
);

  // Guard the width so an illegal Period still elaborates far enough to report the error.
  localparam int unsigned CountW = (Period > 2) ? $clog2(Period) : 1;
  localparam logic [CountW-1:0] LastCount = CountW'(Period - 1);

  // Reject periods that cannot produce a one-cycle-high, at-least-one-cycle-low strobe.
  generate
    if (Period < 2) begin : g_bad_period
      $error("pulse_generator: Period must be >= 2, got %0d", Period);
    end
  endgenerate

  logic [CountW-1:0] count;
  logic [CountW-1:0] count_nxt;
  logic              pulse_nxt;

  // Next-state decode; >= lets an upset into an unused code recover on the next edge.
  always_comb begin
    count_nxt = count + CountW'(1);
    pulse_nxt = 1'b0;
    if (count >= LastCount) begin
      count_nxt = '0;
      pulse_nxt = 1'b1;
    end
  end

  // Counter and strobe flops; pulse is registered so it is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      pulse <= 1'b0;
    end else begin
      count <= count_nxt;
      pulse <= pulse_nxt;
    end
  end

endmodule

// File: tb/tb_pulse_generator.sv
// Bench for pulse_generator: three instances (Period 2, 3, 16) against an edge-count model.
module tb_pulse_generator;

  logic clk;
  logic rst2, rst3, rst16;
  logic pulse2, pulse3, pulse16;

  int n2, n3, n16;     // rising edges seen with rst low since the last reset
  int n_assert;
  int n_fail;

  pulse_generator #(.Period(2))  u_p2  (.clk(clk), .rst(rst2),  .pulse(pulse2));
  pulse_generator #(.Period(3))  u_p3  (.clk(clk), .rst(rst3),  .pulse(pulse3));
  pulse_generator #(.Period(16)) u_p16 (.clk(clk), .rst(rst16), .pulse(pulse16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse is high after edges P, 2P, 3P, ... counted from release.
  function automatic logic exp_pulse(input int n, input int p);
    return (n > 0) && (n % p == 0);
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock, update the model, then sample mid-cycle.
  task automatic tick();
    @(posedge clk);
    if (!rst2)  n2++;
    if (!rst3)  n3++;
    if (!rst16) n16++;
    #5;
    chk("p2",  pulse2,  exp_pulse(n2, 2));
    chk("p3",  pulse3,  exp_pulse(n3, 3));
    chk("p16", pulse16, exp_pulse(n16, 16));
  endtask

  // Reset glitch between two edges on one instance; output must clear immediately.
  task automatic glitch_rst(input int which);
    #2;
    case (which)
      0: begin rst2 = 1'b1;  #1; chk("async_p2",  pulse2,  1'b0); n2 = 0;  #1; rst2 = 1'b0;  end
      1: begin rst3 = 1'b1;  #1; chk("async_p3",  pulse3,  1'b0); n3 = 0;  #1; rst3 = 1'b0;  end
      default: begin rst16 = 1'b1; #1; chk("async_p16", pulse16, 1'b0); n16 = 0; #1; rst16 = 1'b0; end
    endcase
  endtask

  initial begin
    n2 = 0; n3 = 0; n16 = 0;
    n_assert = 0; n_fail = 0;
    rst2 = 1'b1; rst3 = 1'b1; rst16 = 1'b1;

    // Held in reset for 100 cycles: no pulses anywhere.
    repeat (100) tick();

    // Release all and run ten periods of the longest instance.
    rst2 = 1'b0; rst3 = 1'b0; rst16 = 1'b0;
    repeat (160) tick();

    // Edge 160 of Period=16 leaves pulse high; reset during that high cycle.
    chk("p16_high_before_rst", pulse16, 1'b1);
    #1;
    rst16 = 1'b1;
    #1;
    chk("p16_rst_in_pulse", pulse16, 1'b0);
    n16 = 0;
    tick();
    tick();
    rst16 = 1'b0;
    repeat (32) tick();

    // Mid-operation asynchronous reset after edge 10; next pulse must follow edge 16, not 6.
    rst16 = 1'b1; #1; rst16 = 1'b0; n16 = 0;
    repeat (10) tick();
    glitch_rst(2);
    repeat (6) tick();
    chk("p16_not_after_6", pulse16, 1'b0);
    repeat (10) tick();
    chk("p16_after_16", pulse16, 1'b1);
    repeat (16) tick();

    // Randomised run lengths with reset glitches or held resets on random instances.
    for (int k = 0; k < 24; k++) begin
      int run_len;
      int which;
      int hold;
      run_len = int'($urandom_range(1, 40));
      which   = int'($urandom_range(0, 2));
      hold    = int'($urandom_range(0, 3));
      repeat (run_len) tick();
      if (hold == 0) begin
        glitch_rst(which);
      end else begin
        case (which)
          0: begin rst2 = 1'b1; #1; chk("hold_p2", pulse2, 1'b0); n2 = 0; end
          1: begin rst3 = 1'b1; #1; chk("hold_p3", pulse3, 1'b0); n3 = 0; end
          default: begin rst16 = 1'b1; #1; chk("hold_p16", pulse16, 1'b0); n16 = 0; end
        endcase
        repeat (hold) tick();
        rst2 = 1'b0; rst3 = 1'b0; rst16 = 1'b0;
      end
    end
    repeat (40) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_generator.md
# pulse_generator

Free-running periodic strobe source. It emits a single-cycle active-high pulse on `pulse` once every `Period` clock cycles and is held cleared by reset. Downstream blocks use it as a clock-enable or tick, for example for baud-rate ticks, sample strobes or timeouts. It is a leaf block with no handshake.

## Interface

Parameters:
- `Period`, default 16. Pulse period in clock cycles. Integer, must be ≥ 2. Elaboration fails with a clear error if `Period < 2`.

Ports:
- `clk`, input, 1 bit. Single clock; all state updates on the rising edge.
- `rst`, input, 1 bit. Asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `pulse`, output, 1 bit. Registered strobe, high for exactly one `clk` cycle per period.

## Operation

- Internal counter `count` is `$clog2(Period)` bits wide and counts 0 … `Period-1`.
- On each rising `clk` edge with `rst` low:
  - If `count == Period-1`: `count <= 0` and `pulse <= 1`.
  - Otherwise: `count <= count + 1` and `pulse <= 0`.
- `pulse` is a flop output, not a combinational decode of `count`, so it is glitch-free.
- Reset, asynchronous: `count <= 0` and `pulse <= 0` immediately on `rst` rising, regardless of `clk`.
- While `rst` is held high, `pulse` stays 0 indefinitely.
- No enable and no load. The counter free-runs whenever it is out of reset.
- Wrap-around: the counter never exceeds `Period-1`. For non-power-of-2 `Period`, unused codes are unreachable. If one is reached through an upset, the next edge must return to a legal value within one period, so compare with `>=` rather than `==`.

## Timing

- Reset value of `pulse` is 0. Reset value of `count` is 0.
- After `rst` deasserts, number the rising edges 1, 2, 3, … The first is the first edge at which `rst` is low.
  - `pulse` goes high after edge `Period`, edge `2·Period`, and so on.
  - It is high for exactly one cycle each time, and low after every other edge.
- Duty cycle is 1/`Period`. Spacing between consecutive pulse rising edges is exactly `Period` cycles, with no drift.
- Reset asserted mid-period, including during the pulse-high cycle: `pulse` drops to 0 asynchronously. The count restarts from edge 1 after release.
- Reset deassertion should be synchronous to `clk` at system level. This block does not synchronize it.

## Test plan

Clock period is 10 ns. `rst` is high for the first rising edge, then released. Sampling is mid-cycle after each edge.

- **Held in reset:** `rst` = 1 for 100 cycles → `pulse` = 0 at every sample, for both `Period=3` and `Period=16`.
- **Period=3:** after release, over 10 periods, samples read 0,0,1 repeating. `pulse` = 1 only after edges 3, 6, 9, …
- **Period=16:** after release, over 10 periods, 15 samples of 0 then one sample of 1, repeating. The first 1 comes after edge 16.
- **Mid-operation reset:** with `Period=16`, pulse `rst` high asynchronously, between edges, after edge 10 → `pulse` = 0 at once. After release, the next 1 comes after the 16th post-release edge, not the 6th.
- **Reset during the pulse-high cycle:** assert `rst` while `pulse` = 1 → `pulse` falls before the next clock edge. After release, spacing is again exactly `Period`.
- **Period=2:** after release, samples read 0,1,0,1,… This checks the minimum legal parameter.
